crop_window_ctrl: RTL and testbench

Frame-level sequencer for the crop-detection datapath. On a capture request it clears and enables the boundary detectors (X start/end, Y start/end) for whole frames only. After each frame it samples their results and checks the window for geometric validity. It requires the window to be stable across consecutive frames, then latches it for the downstream capture/readout logic. It sits between the sensor-timing front end (frame valid) and the crop detectors and frame-buffer readout.

---
 rtl/crop_window_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_crop_window_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_window_ctrl.sv
// Frame-level sequencer for the crop-detection datapath: arms the boundary detectors on whole
// frames, checks each measured window for geometry and stability, and latches a locked window.
module crop_window_ctrl #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TOL           = 4,
  parameter int unsigned MIN_W         = 16,
  parameter int unsigned MIN_H         = 16,
  parameter int unsigned MAX_TRIES     = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iCAPTURE,
  input  logic        iABORT,
  input  logic [15:0] iXSTART,
  input  logic [15:0] iXEND,
  input  logic [15:0] iYSTART,
  input  logic [15:0] iYEND,
  output logic        oDET_CLR,
  output logic        oDET_EN,
  output logic [15:0] oX0,
  output logic [15:0] oX1,
  output logic [15:0] oY0,
  output logic [15:0] oY1,
  output logic        oWIN_VALID,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StMeasure,
    StSample,
    StCheck,
    StLock,
    StFail
  } state_e;

  localparam logic [15:0] XLimit    = 16'(H_ACTIVE);
  localparam logic [15:0] YLimit    = 16'(V_ACTIVE);
  localparam logic [15:0] XResetEnd = 16'(H_ACTIVE - 1);
  localparam logic [15:0] YResetEnd = 16'(V_ACTIVE - 1);
  localparam logic [15:0] Tol       = 16'(TOL);
  localparam logic [16:0] MinW      = 17'(MIN_W);
  localparam logic [16:0] MinH      = 17'(MIN_H);
  localparam logic [3:0]  StableReq = 4'(STABLE_FRAMES);
  localparam logic [7:0]  MaxTries  = 8'(MAX_TRIES);

  state_e      state_q;
  logic        fval_q;
  logic        det_clr_q, det_en_q, busy_q, done_q, err_q, win_valid_q;
  logic [15:0] x0_q, x1_q, y0_q, y1_q;
  logic [15:0] nx0_q, nx1_q, ny0_q, ny1_q;
  logic [15:0] px0_q, px1_q, py0_q, py1_q;
  logic [3:0]  stable_q, stable_d;
  logic [7:0]  try_q, try_d;

  logic        rise, fall;
  logic        cand_valid, cand_match;
  logic [16:0] cand_w, cand_h;

  assign rise = iFVAL & ~fval_q;
  assign fall = ~iFVAL & fval_q;

  // Larger minus smaller, so the distance never wraps.
  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    cand_w = {1'b0, nx1_q} - {1'b0, nx0_q} + 17'd1;
    cand_h = {1'b0, ny1_q} - {1'b0, ny0_q} + 17'd1;
    cand_valid = (nx1_q > nx0_q) && (ny1_q > ny0_q) &&
                 (nx1_q < XLimit) && (ny1_q < YLimit) &&
                 (cand_w >= MinW) && (cand_h >= MinH);
    cand_match = (abs_diff(nx0_q, px0_q) <= Tol) && (abs_diff(nx1_q, px1_q) <= Tol) &&
                 (abs_diff(ny0_q, py0_q) <= Tol) && (abs_diff(ny1_q, py1_q) <= Tol);
    try_d = try_q + 8'd1;
    if (!cand_valid) begin
      stable_d = 4'd0;
    end else if (cand_match && (stable_q != 4'd0)) begin
      stable_d = stable_q + 4'd1;
    end else begin
      stable_d = 4'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= StIdle;
      fval_q      <= 1'b0;
      det_clr_q   <= 1'b0;
      det_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      x0_q        <= 16'd0;
      x1_q        <= XResetEnd;
      y0_q        <= 16'd0;
      y1_q        <= YResetEnd;
      nx0_q       <= 16'd0;
      nx1_q       <= 16'd0;
      ny0_q       <= 16'd0;
      ny1_q       <= 16'd0;
      px0_q       <= 16'd0;
      px1_q       <= 16'd0;
      py0_q       <= 16'd0;
      py1_q       <= 16'd0;
      stable_q    <= 4'd0;
      try_q       <= 8'd0;
    end else begin
      fval_q    <= iFVAL;
      det_clr_q <= 1'b0;
      done_q    <= 1'b0;
      if (iABORT && (state_q != StIdle)) begin
        state_q  <= StIdle;
        det_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (iCAPTURE && !iABORT) begin
              state_q   <= StArm;
              busy_q    <= 1'b1;
              det_clr_q <= 1'b1;
              err_q     <= 1'b0;
              stable_q  <= 4'd0;
              try_q     <= 8'd0;
            end
          end
          StArm: begin
            if (rise) begin
              state_q  <= StMeasure;
              det_en_q <= 1'b1;
            end
          end
          StMeasure: begin
            if (fall) begin
              state_q  <= StSample;
              det_en_q <= 1'b0;
            end
          end
          StSample: begin
            nx0_q   <= iXSTART;
            nx1_q   <= iXEND;
            ny0_q   <= iYSTART;
            ny1_q   <= iYEND;
            state_q <= StCheck;
          end
          StCheck: begin
            try_q    <= try_d;
            stable_q <= stable_d;
            if (cand_valid) begin
              px0_q <= nx0_q;
              px1_q <= nx1_q;
              py0_q <= ny0_q;
              py1_q <= ny1_q;
            end
            if (stable_d == StableReq) begin
              state_q <= StLock;
            end else if (try_d == MaxTries) begin
              state_q <= StFail;
            end else begin
              state_q   <= StArm;
              det_clr_q <= 1'b1;
            end
          end
          StLock: begin
            // The previous-frame registers hold the most recent valid candidate.
            x0_q        <= px0_q;
            x1_q        <= px1_q;
            y0_q        <= py0_q;
            y1_q        <= py1_q;
            win_valid_q <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
          StFail: begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            det_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oDET_CLR   = det_clr_q;
  assign oDET_EN    = det_en_q;
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oERR       = err_q;
  assign oWIN_VALID = win_valid_q;
  assign oX0        = x0_q;
  assign oX1        = x1_q;
  assign oY0        = y0_q;
  assign oY1        = y1_q;

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Bench for crop_window_ctrl: frame-level event model compared every cycle, plus literal checks.
module tb_crop_window_ctrl;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int STABLE_FRAMES = 3;
  localparam int TOL           = 4;
  localparam int MIN_W         = 16;
  localparam int MIN_H         = 16;
  localparam int MAX_TRIES     = 8;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iFVAL = 1'b0, iCAPTURE = 1'b0, iABORT = 1'b0;
  logic [15:0] iXSTART = '0, iXEND = '0, iYSTART = '0, iYEND = '0;
  logic        oDET_CLR, oDET_EN, oWIN_VALID, oBUSY, oDONE, oERR;
  logic [15:0] oX0, oX1, oY0, oY1;

  crop_window_ctrl #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .STABLE_FRAMES(STABLE_FRAMES), .TOL(TOL),
    .MIN_W(MIN_W), .MIN_H(MIN_H), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iCAPTURE(iCAPTURE), .iABORT(iABORT),
    .iXSTART(iXSTART), .iXEND(iXEND), .iYSTART(iYSTART), .iYEND(iYEND),
    .oDET_CLR(oDET_CLR), .oDET_EN(oDET_EN), .oX0(oX0), .oX1(oX1), .oY0(oY0), .oY1(oY1),
    .oWIN_VALID(oWIN_VALID), .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0, clr_cnt = 0, done_cyc = -1, last_fall = -1;

  always @(posedge iCLK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: tracks the sequence as frames and edge counts since the measured frame ended.
  bit e_clr = 0, e_en = 0, e_busy = 0, e_done = 0, e_err = 0, e_wv = 0;
  int e_win[4] = '{0, H_ACTIVE - 1, 0, V_ACTIVE - 1};
  int cand[4], prev[4];
  int stable = 0, tries = 0, since_fall = -1;
  bit measuring = 0, fv_prev = 0, outcome_lock = 0;

  function automatic bit win_ok(input int w[4]);
    return (w[1] > w[0]) && (w[3] > w[2]) && (w[1] < H_ACTIVE) && (w[3] < V_ACTIVE) &&
           (w[1] - w[0] + 1 >= MIN_W) && (w[3] - w[2] + 1 >= MIN_H);
  endfunction

  function automatic bit win_close(input int a[4], input int b[4]);
    for (int i = 0; i < 4; i++) begin
      if (((a[i] > b[i]) ? a[i] - b[i] : b[i] - a[i]) > TOL) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      e_clr = 0; e_en = 0; e_busy = 0; e_done = 0; e_err = 0; e_wv = 0;
      e_win = '{0, H_ACTIVE - 1, 0, V_ACTIVE - 1};
      stable = 0; tries = 0; since_fall = -1; measuring = 0; fv_prev = 0;
    end else begin
      bit rise, fall;
      rise = iFVAL && !fv_prev;
      fall = !iFVAL && fv_prev;
      fv_prev = iFVAL;
      e_clr = 0;
      e_done = 0;
      if (e_busy && iABORT) begin
        e_busy = 0; e_en = 0; measuring = 0; since_fall = -1;
      end else if (!e_busy) begin
        if (iCAPTURE && !iABORT) begin
          e_busy = 1; e_clr = 1; e_err = 0; stable = 0; tries = 0;
          measuring = 0; since_fall = -1;
        end
      end else if (since_fall >= 0) begin
        since_fall++;
        if (since_fall == 1) begin
          cand = '{int'(iXSTART), int'(iXEND), int'(iYSTART), int'(iYEND)};
        end else if (since_fall == 2) begin
          tries++;
          if (!win_ok(cand)) stable = 0;
          else if (win_close(cand, prev) && stable > 0) stable++;
          else stable = 1;
          if (win_ok(cand)) prev = cand;
          if (stable == STABLE_FRAMES) outcome_lock = 1;
          else if (tries == MAX_TRIES) outcome_lock = 0;
          else begin
            e_clr = 1;
            since_fall = -1;
          end
        end else begin
          if (outcome_lock) begin
            e_win = prev;
            e_wv = 1;
          end else begin
            e_err = 1;
          end
          e_done = 1;
          e_busy = 0;
          since_fall = -1;
        end
      end else if (measuring) begin
        if (fall) begin
          measuring = 0; e_en = 0; since_fall = 0;
        end
      end else if (rise) begin
        measuring = 1; e_en = 1;
      end
    end
  end

  always @(negedge iCLK) begin
    check("det_clr", int'(oDET_CLR), int'(e_clr));
    check("det_en", int'(oDET_EN), int'(e_en));
    check("busy", int'(oBUSY), int'(e_busy));
    check("done", int'(oDONE), int'(e_done));
    check("err", int'(oERR), int'(e_err));
    check("win_valid", int'(oWIN_VALID), int'(e_wv));
    check("x0", int'(oX0), e_win[0]);
    check("x1", int'(oX1), e_win[1]);
    check("y0", int'(oY0), e_win[2]);
    check("y1", int'(oY1), e_win[3]);
    if (oDONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (oDET_CLR) clr_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic set_det(input int x0, input int x1, input int y0, input int y1);
    iXSTART = 16'(x0); iXEND = 16'(x1); iYSTART = 16'(y0); iYEND = 16'(y1);
  endtask

  task automatic frame(input int x0, input int x1, input int y0, input int y1);
    set_det(x0, x1, y0, y1);
    iFVAL = 1'b1;
    tick(20);
    iFVAL = 1'b0;
    last_fall = cyc;
    tick(8);
  endtask

  task automatic capture();
    done_cnt = 0;
    clr_cnt  = 0;
    iCAPTURE = 1'b1;
    tick(1);
    iCAPTURE = 1'b0;
  endtask

  initial begin
    int x0s[4];
    #1 iRST = 1'b0;
    #1;
    check("rst_x1", int'(oX1), 639);
    check("rst_y1", int'(oY1), 479);
    check("rst_win_valid", int'(oWIN_VALID), 0);
    check("rst_busy", int'(oBUSY), 0);
    tick(2);
    iRST = 1'b1;
    tick(2);

    // Clean lock on three close frames.
    capture();
    check("cap_busy", int'(oBUSY), 1);
    check("cap_clr", int'(oDET_CLR), 1);
    frame(160, 479, 120, 300);
    frame(162, 478, 121, 301);
    frame(161, 479, 120, 300);
    check("lock_latency", done_cyc - last_fall, 4);
    check("lock_done_cnt", done_cnt, 1);
    check("lock_clr_cnt", clr_cnt, 3);
    check("lock_x0", int'(oX0), 161);
    check("lock_x1", int'(oX1), 479);
    check("lock_y0", int'(oY0), 120);
    check("lock_y1", int'(oY1), 300);
    check("lock_valid", int'(oWIN_VALID), 1);

    // An out-of-tolerance frame restarts the stability count.
    x0s = '{160, 200, 200, 201};
    capture();
    for (int i = 0; i < 4; i++) frame(x0s[i], 479, 120, 300);
    check("unstable_done_cnt", done_cnt, 1);
    check("unstable_x0", int'(oX0), 201);
    check("unstable_err", int'(oERR), 0);

    // Too-narrow window on every frame: fail after MAX_TRIES, keep prior window.
    capture();
    for (int i = 0; i < MAX_TRIES; i++) frame(300, 310, 120, 300);
    check("fail_done_cnt", done_cnt, 1);
    check("fail_err", int'(oERR), 1);
    check("fail_keep_x0", int'(oX0), 201);
    check("fail_keep_valid", int'(oWIN_VALID), 1);

    // Capture inside a frame: the partial frame is never measured.
    set_det(160, 479, 120, 300);
    iFVAL = 1'b1;
    tick(5);
    capture();
    tick(5);
    check("midarm_en", int'(oDET_EN), 0);
    check("midarm_err_cleared", int'(oERR), 0);
    iFVAL = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) frame(160, 479, 120, 300);
    check("midarm_done_cnt", done_cnt, 1);
    check("midarm_x0", int'(oX0), 160);

    // Capture during MEASURE is ignored; abort drops to idle without done.
    capture();
    iFVAL = 1'b1;
    tick(5);
    check("meas_en", int'(oDET_EN), 1);
    iCAPTURE = 1'b1;
    tick(1);
    iCAPTURE = 1'b0;
    check("meas_clr_ignored", int'(oDET_CLR), 0);
    iABORT = 1'b1;
    tick(1);
    iABORT = 1'b0;
    check("abort_busy", int'(oBUSY), 0);
    check("abort_en", int'(oDET_EN), 0);
    tick(4);
    iFVAL = 1'b0;
    tick(8);
    check("abort_no_done", done_cnt, 0);
    iABORT = 1'b1;
    iCAPTURE = 1'b1;
    tick(1);
    iABORT = 1'b0;
    iCAPTURE = 1'b0;
    check("abort_cap_idle_busy", int'(oBUSY), 0);
    check("abort_cap_idle_clr", int'(oDET_CLR), 0);
    tick(2);

    // Asynchronous reset mid-MEASURE clears the locked window.
    capture();
    iFVAL = 1'b1;
    tick(5);
    #2 iRST = 1'b0;
    #1;
    check("midrst_x0", int'(oX0), 0);
    check("midrst_x1", int'(oX1), 639);
    check("midrst_y1", int'(oY1), 479);
    check("midrst_valid", int'(oWIN_VALID), 0);
    check("midrst_en", int'(oDET_EN), 0);
    check("midrst_busy", int'(oBUSY), 0);
    tick(2);
    iRST = 1'b1;
    iFVAL = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
